// File: rtl/chunked_block_memory_pkg.sv
// Shared definitions for the chunked block memory: bus chunk width, chunk
// count helper and the bus request/response record.
package chunked_block_memory_pkg;

    localparam int unsigned BUS_WIDTH = 16;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] addr;
        logic [BUS_WIDTH-1:0] data;
        logic                 rw;
        logic                 valid;
    } bus_msg_t;

    function automatic int unsigned num_chunks(input int unsigned width);
        return (width + BUS_WIDTH - 1) / BUS_WIDTH;
    endfunction

endpackage

// File: rtl/chunked_block_memory_dual_port_bram.sv
// Single-clock true dual-port RAM with registered reads on both ports.
// Callers resolve same-address write collisions before driving the enables.
module chunked_block_memory_dual_port_bram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [WIDTH-1:0]         din_a,
    input  logic                     we_a,
    output logic [WIDTH-1:0]         dout_a,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [WIDTH-1:0]         din_b,
    input  logic                     we_b,
    output logic [WIDTH-1:0]         dout_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
    end

    // Reads see the contents before any write at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            dout_a <= mem[addr_a];
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/chunked_block_memory.sv
// Block memory of DEPTH x WIDTH words exposed as 16-bit chunks on the register
// bus, with atomic staged word writes and a full-width user port.
module chunked_block_memory
    import chunked_block_memory_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned WIDTH     = 33,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              addr_i,
    input  logic [15:0]              data_i,
    input  logic                     rw_i,
    input  logic                     valid_i,
    output logic [15:0]              addr_o,
    output logic [15:0]              data_o,
    output logic                     rw_o,
    output logic                     valid_o,
    input  logic [$clog2(DEPTH)-1:0] user_addr,
    input  logic [WIDTH-1:0]         user_din,
    output logic [WIDTH-1:0]         user_dout,
    input  logic                     user_we
);

    localparam int unsigned N_CHUNKS = num_chunks(WIDTH);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int unsigned STAGE_N  = (N_CHUNKS > 1) ? N_CHUNKS - 1 : 1;
    localparam int unsigned LOW_W    = BUS_WIDTH * (N_CHUNKS - 1);
    localparam int unsigned TOP_W    = WIDTH - LOW_W;
    localparam int unsigned PAD_W    = BUS_WIDTH * N_CHUNKS;
    localparam logic [31:0] SPAN     = 32'(DEPTH * N_CHUNKS);

    bus_msg_t               req_p0;
    bus_msg_t               req_p1;
    logic                   in_range_p1;
    logic [CW-1:0]          chunk_p1;

    logic [32:0]            diff_p0;
    logic                   in_range_p0;
    logic [AW-1:0]          word_p0;
    logic [CW-1:0]          chunk_p0;
    logic                   bus_write_p0;
    logic                   commit_p0;
    logic                   bus_we;

    logic [BUS_WIDTH-1:0]   staging [STAGE_N];
    logic [WIDTH-1:0]       commit_din;
    logic [WIDTH-1:0]       bus_dout;
    logic [PAD_W-1:0]       read_padded;
    logic [BUS_WIDTH-1:0]   read_chunk;

    // Address decode of the request held in stage p0; the borrow bit flags
    // addresses below BASE_ADDR.
    always_comb begin
        diff_p0      = {17'd0, req_p0.addr} - 33'(BASE_ADDR);
        in_range_p0  = !diff_p0[32] && (diff_p0[31:0] < SPAN);
        word_p0      = AW'(diff_p0[31:0] / N_CHUNKS);
        chunk_p0     = CW'(diff_p0[31:0] % N_CHUNKS);
        bus_write_p0 = req_p0.valid && req_p0.rw && in_range_p0;
        commit_p0    = bus_write_p0 && (chunk_p0 == CW'(N_CHUNKS - 1));
        // A user write to the same word at the same edge wins.
        bus_we       = commit_p0 && !(user_we && (user_addr == word_p0)) && !rst;
    end

    always_comb begin
        commit_din = '0;
        for (int i = 0; i < int'(N_CHUNKS) - 1; i++) begin
            commit_din[i*BUS_WIDTH +: BUS_WIDTH] = staging[i];
        end
        commit_din[WIDTH-1:LOW_W] = req_p0.data[TOP_W-1:0];
    end

    always_comb begin
        read_padded              = '0;
        read_padded[WIDTH-1:0]   = bus_dout;
        read_chunk               = '0;
        for (int i = 0; i < int'(N_CHUNKS); i++) begin
            if (chunk_p1 == CW'(i)) read_chunk = read_padded[i*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_p0      <= '0;
            req_p1      <= '0;
            in_range_p1 <= 1'b0;
            chunk_p1    <= '0;
            addr_o      <= '0;
            data_o      <= '0;
            rw_o        <= 1'b0;
            valid_o     <= 1'b0;
            for (int i = 0; i < int'(STAGE_N); i++) staging[i] <= '0;
        end else begin
            // p0: capture the bus request
            req_p0 <= '{addr: addr_i, data: data_i, rw: rw_i, valid: valid_i};

            // p1: staging update and RAM access happen at this edge
            req_p1      <= req_p0;
            in_range_p1 <= in_range_p0;
            chunk_p1    <= chunk_p0;
            if (bus_write_p0) begin
                for (int i = 0; i < int'(N_CHUNKS) - 1; i++) begin
                    if (chunk_p0 == CW'(i)) staging[i] <= req_p0.data;
                end
            end

            // p2: bus response
            valid_o <= req_p1.valid;
            addr_o  <= req_p1.addr;
            rw_o    <= req_p1.rw;
            data_o  <= (in_range_p1 && !req_p1.rw) ? read_chunk : req_p1.data;
        end
    end

    chunked_block_memory_dual_port_bram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .addr_a (word_p0),
        .din_a  (commit_din),
        .we_a   (bus_we),
        .dout_a (bus_dout),
        .addr_b (user_addr),
        .din_b  (user_din),
        .we_b   (user_we),
        .dout_b (user_dout)
    );

endmodule

// File: tb/tb_chunked_block_memory.sv
// Directed bench for chunked_block_memory: two instances (BASE_ADDR 0 and 0x100)
// with a queue of expected bus responses checked as they emerge.
module tb_chunked_block_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] a_addr, a_data, a_raddr, a_rdata;
    logic        a_rw, a_valid, a_rrw, a_rvalid, a_uwe;
    logic [7:0]  a_uaddr;
    logic [32:0] a_udin, a_udout;
    logic [15:0] b_addr, b_data, b_raddr, b_rdata;
    logic        b_rw, b_valid, b_rrw, b_rvalid, b_uwe;
    logic [7:0]  b_uaddr;
    logic [32:0] b_udin, b_udout;

    chunked_block_memory #(.DEPTH(256), .WIDTH(33), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .addr_i(a_addr), .data_i(a_data), .rw_i(a_rw), .valid_i(a_valid),
        .addr_o(a_raddr), .data_o(a_rdata), .rw_o(a_rrw), .valid_o(a_rvalid),
        .user_addr(a_uaddr), .user_din(a_udin), .user_dout(a_udout), .user_we(a_uwe)
    );

    chunked_block_memory #(.DEPTH(256), .WIDTH(33), .BASE_ADDR(16'h0100)) dut_b (
        .clk(clk), .rst(rst),
        .addr_i(b_addr), .data_i(b_data), .rw_i(b_rw), .valid_i(b_valid),
        .addr_o(b_raddr), .data_o(b_rdata), .rw_o(b_rrw), .valid_o(b_rvalid),
        .user_addr(b_uaddr), .user_din(b_udin), .user_dout(b_udout), .user_we(b_uwe)
    );

    typedef struct {
        int          due;
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one bus request for a single cycle; the response is due three
    // negedges later (sampled edge + 2 pipeline edges).
    task automatic bus_req(input bit sel, input logic [15:0] a, input logic [15:0] d,
                           input logic rw, input logic [15:0] rd, input bit push);
        exp_t e;
        e.due  = cyc + 3;
        e.addr = a;
        e.data = rw ? d : rd;
        e.rw   = rw;
        if (!sel) begin
            a_addr = a; a_data = d; a_rw = rw; a_valid = 1'b1;
            if (push) q_a.push_back(e);
        end else begin
            b_addr = a; b_data = d; b_rw = rw; b_valid = 1'b1;
            if (push) q_b.push_back(e);
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic user_write(input bit sel, input logic [7:0] w, input logic [32:0] v);
        if (!sel) begin a_uaddr = w; a_udin = v; a_uwe = 1'b1; end
        else      begin b_uaddr = w; b_udin = v; b_uwe = 1'b1; end
        @(negedge clk);
        a_uwe = 1'b0;
        b_uwe = 1'b0;
    endtask

    task automatic user_read(input bit sel, input logic [7:0] w, input logic [32:0] exp,
                             input string tag);
        if (!sel) a_uaddr = w; else b_uaddr = w;
        @(negedge clk);
        check(tag, sel ? b_udout : a_udout, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Response scoreboard for both instances.
    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        ev = (q_a.size() > 0) && (q_a[0].due == cyc);
        if (ev || a_rvalid) begin
            check("a_valid_o", a_rvalid, ev);
            if (ev) begin
                e = q_a.pop_front();
                check("a_addr_o", a_raddr, e.addr);
                check("a_data_o", a_rdata, e.data);
                check("a_rw_o", a_rrw, e.rw);
            end
        end
        ev = (q_b.size() > 0) && (q_b[0].due == cyc);
        if (ev || b_rvalid) begin
            check("b_valid_o", b_rvalid, ev);
            if (ev) begin
                e = q_b.pop_front();
                check("b_addr_o", b_raddr, e.addr);
                check("b_data_o", b_rdata, e.data);
                check("b_rw_o", b_rrw, e.rw);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_addr = '0; a_data = '0; a_rw = 1'b0; a_valid = 1'b0;
        a_uaddr = '0; a_udin = '0; a_uwe = 1'b0;
        b_addr = '0; b_data = '0; b_rw = 1'b0; b_valid = 1'b0;
        b_uaddr = '0; b_udin = '0; b_uwe = 1'b0;
        idle(3);
        check("rst_valid_o", a_rvalid, 1'b0);
        check("rst_addr_o", a_raddr, 16'h0);
        check("rst_data_o", a_rdata, 16'h0);
        check("rst_rw_o", a_rrw, 1'b0);
        check("rst_user_dout", a_udout, 33'h0);
        check("rst_b_valid_o", b_rvalid, 1'b0);
        rst = 1'b0;
        idle(1);

        // Atomic wide write, then read back over both ports
        bus_req(0, 16'd15, 16'h6789, 1'b1, 16'h0, 1);
        bus_req(0, 16'd16, 16'h2345, 1'b1, 16'h0, 1);
        bus_req(0, 16'd17, 16'h0001, 1'b1, 16'h0, 1);
        idle(2);
        user_read(0, 8'd5, 33'h1_2345_6789, "wide_write_word5");
        bus_req(0, 16'd15, 16'h0, 1'b0, 16'h6789, 1);
        bus_req(0, 16'd16, 16'h0, 1'b0, 16'h2345, 1);
        bus_req(0, 16'd17, 16'h0, 1'b0, 16'h0001, 1);
        bus_req(0, 16'd15, 16'h0, 1'b0, 16'h6789, 1);
        check("burst_valid_2", a_rvalid, 1'b1);
        idle(1);
        check("burst_valid_3", a_rvalid, 1'b1);
        idle(1);
        check("burst_valid_4", a_rvalid, 1'b1);
        idle(1);
        check("burst_end", a_rvalid, 1'b0);

        // Partial write stays staged until the top chunk arrives
        bus_req(0, 16'd15, 16'hAAAA, 1'b1, 16'h0, 1);
        idle(2);
        user_read(0, 8'd5, 33'h1_2345_6789, "partial_held");
        bus_req(0, 16'd15, 16'h0, 1'b0, 16'h6789, 1);
        bus_req(0, 16'd17, 16'h0000, 1'b1, 16'h0, 1);
        idle(2);
        user_read(0, 8'd5, 33'h0_2345_AAAA, "partial_commit");

        // User write visible on the bus; top chunk upper bits ignored
        user_write(0, 8'd1, 33'h1_FFFF_0000);
        bus_req(0, 16'd3, 16'h0, 1'b0, 16'h0000, 1);
        bus_req(0, 16'd4, 16'h0, 1'b0, 16'hFFFF, 1);
        bus_req(0, 16'd5, 16'h0, 1'b0, 16'h0001, 1);
        bus_req(0, 16'd3, 16'h0000, 1'b1, 16'h0, 1);
        bus_req(0, 16'd4, 16'h0000, 1'b1, 16'h0, 1);
        bus_req(0, 16'd5, 16'hFFFF, 1'b1, 16'h0, 1);
        idle(2);
        user_read(0, 8'd1, 33'h1_0000_0000, "top_chunk_pad");

        // Collision on word 7, then simultaneous writes to different words
        bus_req(0, 16'd23, 16'h0001, 1'b1, 16'h0, 1);
        user_write(0, 8'd7, 33'h0_1234_5678);
        bus_req(0, 16'd26, 16'h0001, 1'b1, 16'h0, 1);
        user_write(0, 8'd9, 33'h0_0BAD_F00D);
        idle(2);
        user_read(0, 8'd7, 33'h0_1234_5678, "collision_user_wins");
        user_read(0, 8'd8, 33'h1_0000_0000, "no_collision_bus");
        user_read(0, 8'd9, 33'h0_0BAD_F00D, "no_collision_user");

        // Pass-through and range boundaries on the BASE_ADDR=0x100 instance
        user_write(1, 8'd5, 33'h1_2345_6789);
        bus_req(1, 16'h0010, 16'hBEEF, 1'b1, 16'h0, 1);
        bus_req(1, 16'h0400, 16'h1234, 1'b0, 16'h1234, 1);
        bus_req(1, 16'h03FF, 16'h0003, 1'b1, 16'h0, 1);
        bus_req(1, 16'h010F, 16'h0, 1'b0, 16'h6789, 1);
        bus_req(1, 16'h0111, 16'h0, 1'b0, 16'h0001, 1);
        idle(2);
        user_read(1, 8'd255, 33'h1_0000_0000, "b_last_word");
        user_read(1, 8'd5, 33'h1_2345_6789, "b_passthrough_no_write");

        // Reset with staged chunks and a read in flight
        bus_req(0, 16'd0, 16'h1111, 1'b1, 16'h0, 1);
        bus_req(0, 16'd1, 16'h2222, 1'b1, 16'h0, 1);
        idle(3);
        bus_req(0, 16'd15, 16'h0, 1'b0, 16'h0, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_user_dout", a_udout, 33'h0);
        check("mid_rst_valid_o", a_rvalid, 1'b0);
        check("mid_rst_data_o", a_rdata, 16'h0);
        idle(3);
        bus_req(0, 16'd2, 16'h0001, 1'b1, 16'h0, 1);
        idle(2);
        user_read(0, 8'd0, 33'h1_0000_0000, "rst_lost_staging");
        bus_req(0, 16'd0, 16'h0, 1'b0, 16'h0000, 1);
        bus_req(0, 16'd2, 16'h0, 1'b0, 16'h0001, 1);

        idle(6);
        check("a_queue_drained", 33'(q_a.size()), 33'h0);
        check("b_queue_drained", 33'(q_b.size()), 33'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/chunked_block_memory.md
Name: chunked_block_memory

Overview:
- Next-generation block memory for the 16-bit register bus.
- Holds DEPTH words of arbitrary WIDTH, bus-mapped as ceil(WIDTH/16) 16-bit chunks per word at a configurable BASE_ADDR.
- Bus writes to a word are atomic: lower chunks stage until the top chunk commits.
- A pipelined user port on the same clock gives full-word access, with defined collision priority and synchronous reset of all pipeline state.

Parameters:
- DEPTH, 256, number of words.
- WIDTH, 33, bits per word; any value ≥1.
- BASE_ADDR, 0, first bus address owned by this block.

Ports:
- clk  input  1  system clock (bus and user side)
- rst  input  1  synchronous active-high reset
- addr_i  input  16  bus request address
- data_i  input  16  bus request write data
- rw_i  input  1  1 = write, 0 = read
- valid_i  input  1  bus request strobe, one request per cycle max
- addr_o  output  16  bus response address
- data_o  output  16  bus response data
- rw_o  output  1  bus response rw
- valid_o  output  1  bus response strobe
- user_addr  input  $clog2(DEPTH)  user word address
- user_din  input  WIDTH  user write data
- user_dout  output  WIDTH  user read data
- user_we  input  1  user write enable

Behaviour:
- Chunk and address mapping:
  - N_CHUNKS = ceil(WIDTH/16); bus range is BASE_ADDR .. BASE_ADDR + DEPTH*N_CHUNKS - 1.
  - Word index = (addr_i - BASE_ADDR) / N_CHUNKS; chunk index = (addr_i - BASE_ADDR) % N_CHUNKS; chunk 0 holds bits [15:0].
  - The last chunk carries WIDTH - 16*(N_CHUNKS-1) valid bits. Reads zero-pad its upper bits; writes ignore them.
- Bus latency:
  - A request sampled with valid_i=1 at edge T produces valid_o=1 for exactly one cycle after edge T+2.
  - addr_o and rw_o are the delayed request values.
  - Fully pipelined: back-to-back requests give back-to-back responses in order.
- Out-of-range request: addr_o, data_o and rw_o pass through unchanged with the same 2-cycle latency. Memory and staging are untouched.
- In-range read: data_o = addressed chunk of the stored word, as read at edge T+1.
- In-range write: data_o echoes data_i.
  - Chunk < N_CHUNKS-1: data goes into a shared staging register slot; memory is unchanged.
  - Chunk = N_CHUNKS-1: {data_i, staged chunks N-2..0} is written to the addressed word at edge T+1. Staging is not cleared.
  - Staging is shared, not per-word; the commit target is the word addressed by the top-chunk write.
  - N_CHUNKS=1: every write commits directly.
- User port:
  - Read latency is 1 cycle: user_dout after edge T+1 holds the word at user_addr sampled at edge T.
  - With user_we=1, user_din is written at the edge. Read-during-write returns the old data.
- Collision: bus commit and user write to the same word at the same edge → user data is stored and the bus commit is discarded. The bus response is still issued.
- Reset (synchronous):
  - valid_o=0; addr_o, data_o and rw_o = 0; user_dout=0.
  - Staging register is cleared to 0; pipeline requests in flight are dropped with no response.
  - Memory contents are not cleared.
- Reset mid-sequence: previously staged chunks are lost. A later top-chunk write commits using zeros for the lower chunks.
- Resource target: inferable dual-port RAM with one write port per side.

Decomposition:
- bus_pkg:
  - BUS_WIDTH=16.
  - Function num_chunks(width).
  - Struct bus_msg_t {addr, data, rw, valid}.
- Sub-module dual_port_bram #(DEPTH, WIDTH): single clock, two read/write ports, registered read.
  - Collision priority is resolved in chunked_block_memory by gating the bus write enable, not inside the RAM.

Test Plan:
(WIDTH=33, DEPTH=256, N_CHUNKS=3 unless noted.)
1. Atomic wide write:
   - Bus writes addr 15=0x6789, 16=0x2345, 17=0x0001 → user read word 5 = 33'h1_2345_6789.
   - Bus reads of addr 15/16/17 return 0x6789/0x2345/0x0001, valid_o at T+2.
2. Partial write held:
   - Write addr 15=0xAAAA only → user read word 5 unchanged (33'h1_2345_6789); bus read addr 15 returns 0x6789.
   - Then write addr 17=0x0000 → word 5 = 33'h0_2345_AAAA.
3. User write and top-chunk padding:
   - User writes word 1=33'h1_FFFF_0000 → bus reads addr 3/4/5 = 0x0000/0xFFFF/0x0001.
   - Bus writes addr 3=0, 4=0, 5=0xFFFF → user read word 1 = 33'h1_0000_0000.
4. Pass-through and pipelining:
   - BASE_ADDR=0x100. Write addr 0x0010 data 0xBEEF → response addr 0x0010, data 0xBEEF, rw 1 at T+2; memory unchanged.
   - Four back-to-back in-range reads → four consecutive valid_o cycles, in order.
5. Collision:
   - Bus commit to word 7 (top chunk addr 23) and user write word 7=33'h0_1234_5678 at the same edge → user read word 7 = 33'h0_1234_5678.
   - Bus response is still issued.
6. Reset mid-operation:
   - Write addr 0=0x1111, addr 1=0x2222, pulse rst 1 cycle with a read in flight → no valid_o for that read.
   - Write addr 2=0x0001 → word 0 = 33'h1_0000_0000; user_dout=0 right after reset.
